// File: rtl/io_bus.sv
// io_bus: memory-mapped I/O hub between the CPU bus and RAM.
// It decodes four I/O registers: frame timer, status, random LFSR and key FIFO.
// It steers CPU read data from either those registers or RAM.
// It blocks RAM write-enable whenever the address hits an I/O register.
module io_bus #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    KEY_DEPTH   = 4,
  parameter int                    TIMER_DIV   = 1000,
  parameter logic [ADDR_WIDTH-1:0] TIMER_ADDR  = 16'h00FC,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 16'h00FD,
  parameter logic [ADDR_WIDTH-1:0] RANDOM_ADDR = 16'h00FE,
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR    = 16'h00FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_read_write,
  input  logic [7:0]            cpu_data_write,
  input  logic                  access_valid,
  input  logic [7:0]            mem_data,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  output logic [7:0]            cpu_data_read,
  output logic                  mem_wren,
  output logic                  irq
);

  localparam int PTR_W = $clog2(KEY_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = $clog2(TIMER_DIV);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(KEY_DEPTH);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TIMER_DIV - 1);
  localparam logic [7:0]       LFSR_MASK  = 8'hB8;

  // Registered state
  logic [7:0]       r_lfsr;
  logic [7:0]       r_timer;
  logic [PRE_W-1:0] r_prescaler;
  logic [7:0]       r_key_mem [KEY_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_tick;
  logic             r_irq;

  // Decode and control wires
  logic       w_sel_timer;
  logic       w_sel_status;
  logic       w_sel_random;
  logic       w_sel_key;
  logic       w_io_hit;
  logic       w_write;
  logic       w_read;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic       w_timer_wr;
  logic       w_status_wr;
  logic       w_random_wr;
  logic       w_terminal;
  logic       w_tick_set;
  logic [7:0] w_status;
  logic [7:0] w_key_head;
  logic [7:0] w_lfsr_step;
  logic [7:0] w_read_data;

  assign w_sel_timer  = (cpu_address == TIMER_ADDR);
  assign w_sel_status = (cpu_address == STATUS_ADDR);
  assign w_sel_random = (cpu_address == RANDOM_ADDR);
  assign w_sel_key    = (cpu_address == KEY_ADDR);
  assign w_io_hit     = w_sel_timer | w_sel_status | w_sel_random | w_sel_key;

  assign w_write = access_valid & cpu_read_write;
  assign w_read  = access_valid & ~cpu_read_write;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
  // when it is being read; an empty FIFO ignores the pop and only pushes.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = w_read & w_sel_key & ~w_empty;
  assign w_push  = key_valid & (~w_full | w_pop);
  assign w_drop  = key_valid & w_full & ~w_pop;

  assign w_timer_wr  = w_write & w_sel_timer;
  assign w_status_wr = w_write & w_sel_status;
  assign w_random_wr = w_write & w_sel_random;

  // A timer write restarts the prescaler and suppresses that cycle's increment.
  assign w_terminal = (r_prescaler == PRE_LAST);
  assign w_tick_set = w_terminal & ~w_timer_wr;

  assign w_status    = {4'b0000, r_tick, r_overflow, w_full, ~w_empty};
  assign w_key_head  = w_empty ? 8'h00 : r_key_mem[r_rd_ptr];
  assign w_lfsr_step = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_MASK : 8'h00);

  // RAM never sees a write aimed at an I/O register; access_valid is not involved.
  assign mem_wren = cpu_read_write & ~w_io_hit;
  assign irq      = r_irq;

  // Read steering: I/O registers first, RAM data for every other address.
  always_comb begin
    // NOTE: the default comes first so every path assigns the output and no latch is inferred.
    w_read_data = mem_data;
    if (w_sel_timer) begin
      w_read_data = r_timer;
    end else if (w_sel_status) begin
      w_read_data = w_status;
    end else if (w_sel_random) begin
      w_read_data = r_lfsr;
    end else if (w_sel_key) begin
      w_read_data = w_key_head;
    end
  end

  assign cpu_data_read = w_read_data;

  // LFSR: steps every cycle; a CPU load replaces the step, and zero is forced to 1.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_lfsr <= 8'h01;
    end else if (w_random_wr) begin
      r_lfsr <= (cpu_data_write == 8'h00) ? 8'h01 : cpu_data_write;
    end else begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Frame timer: prescaler divides clk by TIMER_DIV; the CPU may reload the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= 8'h00;
      r_prescaler <= '0;
    end else if (w_timer_wr) begin
      r_timer     <= cpu_data_write;
      r_prescaler <= '0;
    end else if (w_terminal) begin
      r_timer     <= r_timer + 8'd1;
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + PRE_W'(1);
    end
  end

  // Key FIFO storage: written on every accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count and pointers alone define which entries are valid.
    if (w_push) begin
      r_key_mem[r_wr_ptr] <= key_code;
    end
  end

  // Key FIFO pointers and occupancy; pointers wrap because KEY_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags with write-1-to-clear (a set in the same cycle wins) and the lagging irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_tick     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_status_wr && cpu_data_write[2]) begin
        r_overflow <= 1'b0;
      end
      if (w_tick_set) begin
        r_tick <= 1'b1;
      end else if (w_status_wr && cpu_data_write[3]) begin
        r_tick <= 1'b0;
      end
      r_irq <= r_overflow | r_tick;
    end
  end

endmodule

// File: doc/io_bus.md
# io_bus

Parametrised memory-mapped I/O hub between the CPU bus and RAM. It supersedes the fixed combinational CPU read multiplexer with four stateful peripheral registers:
- random LFSR
- buffered keypad FIFO
- status register with write-1-to-clear flags
- free-running frame timer

It steers CPU read data and gates RAM write-enable so I/O addresses never alias RAM.

## Interface
Parameters:
- ADDR_WIDTH, 16, CPU address width
- KEY_DEPTH, 4, key FIFO entries; power of two, ≥2
- TIMER_DIV, 1000, clk cycles per timer increment; ≥2
- TIMER_ADDR, 16'h00FC, timer register address
- STATUS_ADDR, 16'h00FD, status register address
- RANDOM_ADDR, 16'h00FE, LFSR register address
- KEY_ADDR, 16'h00FF, key FIFO pop address

Ports:
- clk  in  1  system clock; one clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_address  in  ADDR_WIDTH  CPU address
- cpu_read_write  in  1  1 = write, 0 = read
- cpu_data_write  in  8  CPU write data
- access_valid  in  1  one-cycle pulse qualifying one CPU bus access; side effects only occur when it is high
- mem_data  in  8  RAM read data for cpu_address
- key_valid  in  1  one-cycle pulse, new key present
- key_code  in  8  key value, sampled when key_valid=1
- cpu_data_read  out  8  read data to CPU (combinational from address and registered state)
- mem_wren  out  1  RAM write enable = cpu_read_write & ~io_hit
- irq  out  1  registered; high while status bit2 or bit3 is set

## Operation
- io_hit: cpu_address equals any of the four I/O addresses.
- Read mux:
  - TIMER_ADDR → timer
  - STATUS_ADDR → status
  - RANDOM_ADDR → lfsr
  - KEY_ADDR → FIFO head, or 8'h00 if empty
  - any other address → mem_data
- LFSR, 8-bit Galois, mask 8'hB8:
  - Every cycle: lfsr ← (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 0).
  - Reset value 8'h01.
  - Write to RANDOM_ADDR loads cpu_data_write; a written 8'h00 loads 8'h01 instead. The lfsr never holds 0.
- Key FIFO (count 0..KEY_DEPTH, wrapping read/write pointers):
  - Push on key_valid when not full.
  - key_valid while full: key dropped, overflow flag set.
  - Pop on read access of KEY_ADDR when not empty.
  - Pop when empty is a no-op; read returns 8'h00.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push only; read returns 8'h00; count becomes 1.
  - Writes to KEY_ADDR are ignored.
- Status bits:
  - bit0 = count≠0
  - bit1 = count==KEY_DEPTH
  - bit2 = overflow (sticky)
  - bit3 = tick (sticky)
  - bits[7:4] = 0
  - Write to STATUS_ADDR: each 1 in cpu_data_write[3:2] clears the matching sticky flag; bits 1:0 and 7:4 are ignored.
  - A set event in the same cycle as its clear wins: flag stays 1.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1.
  - On terminal count: timer ← timer+1 (mod 256), tick flag set.
  - Write to TIMER_ADDR: timer ← cpu_data_write, prescaler ← 0, and no increment that cycle.

## Timing
- Reset, applied at the clock edge while rst=1:
  - lfsr=8'h01, timer=0, prescaler=0
  - FIFO empty, pointers 0
  - overflow=0, tick=0, irq=0
  - After reset, cpu_data_read at STATUS_ADDR = 8'h00.
- Reset overrides all concurrent accesses and key pushes. Reset mid-fill discards FIFO contents.
- Read latency: zero cycles. cpu_data_read is valid in the same cycle as cpu_address; the pop takes effect at the next edge.
- Write side effects update at the edge ending the access_valid cycle.
- A key pushed at edge N is readable in cycle N+1.
- irq lags its flags by one cycle.
- mem_wren is purely combinational and does not depend on access_valid (the RAM is clocked by the CPU side).
- First timer increment comes TIMER_DIV cycles after reset or after a timer write.

## Test plan
- Reset, then read STATUS_ADDR and RANDOM_ADDR → 8'h00 and 8'h01. One cycle later, RANDOM_ADDR reads 8'hB8.
- Push keys 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with KEY_DEPTH=4:
  - after the 5th push: status = 8'h07, irq=1 the next cycle
  - four KEY_ADDR reads return 11, 22, 33, 44
  - fifth read returns 8'h00
  - status then reads 8'h04
- Write 8'h04 to STATUS_ADDR → status 8'h00, irq falls. Repeat the write in the same cycle as a full-FIFO key_valid → bit2 stays set.
- With TIMER_DIV=4, write 8'hFF to TIMER_ADDR:
  - 4 cycles later, timer = 8'h00 and status bit3=1
  - 8 cycles after the write, timer = 8'h01
- Write to 16'h0200 → mem_wren=1. Write to each I/O address → mem_wren=0. Read at 16'h0200 returns mem_data unchanged.
- Write 8'h00 to RANDOM_ADDR → lfsr reads 8'h01 next cycle. Full FIFO with simultaneous push and pop → count stays 4, overflow stays 0.
